// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver (device-to-host only).
// Synchronises and de-glitches kclk/kd, deframes 11-bit frames (start, 8 data
// LSB-first, odd parity, stop) and queues good bytes behind a valid/ready port.
// Build option: define PS2_RX_FIFO_EN for a 2**FIFO_AW-entry first-word-fall-through
// FIFO; otherwise the queue is a single holding register.
// Handshake: vld_o is high while dat_o holds an unread byte; the byte is consumed on
// any rising clk edge where vld_o && rdy_i, and dat_o does not change while vld_o=1
// and rdy_i=0. vld_o never waits on rdy_i.
module ps2_kbd_rx #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = CLK_FREQ / 10000,
    parameter int FIFO_AW     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kd,
    output logic [7:0] dat_o,
    output logic       vld_o,
    input  logic       rdy_i,
    output logic       err_par_o,
    output logic       err_frm_o,
    output logic       ovf_o,
    output logic       busy_o
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    if (FIFO_AW < 1 || FILTER_LEN < 1 || TIMEOUT_CYC < 2) begin : g_param_chk
        $error("ps2_kbd_rx: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // FSM state; named state_q so a checker can bind to it directly.
    state_t         state_q, state_d;
    logic [7:0]     sr_q, sr_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic           par_q, par_d;
    logic [TCW-1:0] tcnt_q;
    logic           kclk_s1, kclk_s2, kd_s1, kd_s2;
    logic           kclk_f;
    logic [FCW-1:0] fcnt;
    logic           fall;
    logic           push, perr_d, ferr_d, pop, timeout;

    // Two-flop synchronisers for both pins, preset to the idle-high level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_s1 <= 1'b1;
            kclk_s2 <= 1'b1;
            kd_s1   <= 1'b1;
            kd_s2   <= 1'b1;
        end else begin
            kclk_s1 <= kclk;
            kclk_s2 <= kclk_s1;
            kd_s1   <= kd;
            kd_s2   <= kd_s1;
        end
    end

    // kclk filter: the filtered level follows only after FILTER_LEN consecutive
    // differing samples; fall is a one-cycle strobe on a filtered 1->0 change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_f <= 1'b1;
            fcnt   <= '0;
            fall   <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (kclk_s2 == kclk_f) begin
                fcnt <= '0;
            end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
                kclk_f <= kclk_s2;
                fcnt   <= '0;
                fall   <= kclk_f;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // FSM state, shift register, bit counter, parity latch and inter-bit timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bitcnt_q  <= '0;
            par_q     <= 1'b0;
            tcnt_q    <= '0;
            err_par_o <= 1'b0;
            err_frm_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bitcnt_q  <= bitcnt_d;
            par_q     <= par_d;
            err_par_o <= perr_d;
            err_frm_o <= ferr_d;
            if (state_q == IDLE || fall) tcnt_q <= '0;
            else                         tcnt_q <= tcnt_q + 1'b1;
        end
    end

    assign timeout = (state_q != IDLE) && !fall && (tcnt_q == TCW'(TIMEOUT_CYC - 1));

    // Frame decoder: advances on fall; a stalled kclk inside a frame aborts it.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        push     = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: if (fall && !kd_s2) begin
                state_d  = DATA;
                bitcnt_d = '0;
            end
            DATA: if (fall) begin
                sr_d     = {kd_s2, sr_q[7:1]};
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
                par_d   = kd_s2;
                state_d = STOP;
            end
            STOP: if (fall) begin
                state_d = IDLE;
                if (!kd_s2)              ferr_d = 1'b1;
                else if (^{sr_q, par_q}) push   = 1'b1;
                else                     perr_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign pop    = vld_o && rdy_i;

`ifdef PS2_RX_FIFO_EN
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   cnt;
    logic               full, push_ok;

    assign full    = (cnt == (FIFO_AW + 1)'(DEPTH));
    assign push_ok = push && (!full || pop);
    assign vld_o   = (cnt != '0);
    assign dat_o   = vld_o ? mem[rptr] : 8'h00;

    // FIFO storage; a push into a full FIFO succeeds only if a pop frees a slot.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= sr_q;
    end

    // FIFO pointers, occupancy and overflow pulse; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ovf_o <= 1'b0;
        end else begin
            ovf_o <= push && !push_ok;
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
`else
    logic [7:0] hold;
    logic       hold_vld;

    assign vld_o = hold_vld;
    assign dat_o = hold;

    // Single holding register; a simultaneous pop makes room for the push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= '0;
            hold_vld <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            ovf_o <= 1'b0;
            if (push) begin
                if (!hold_vld || pop) begin
                    hold     <= sr_q;
                    hold_vld <= 1'b1;
                end else begin
                    ovf_o <= 1'b1;
                end
            end else if (pop) begin
                hold_vld <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed bench for ps2_kbd_rx. The system clock is scaled to 1 MHz
// so the inter-bit timeout is 100 cycles and one kclk period is 40 cycles.
module tb_ps2_kbd_rx;

    localparam int AW = 3;
`ifdef PS2_RX_FIFO_EN
    localparam int DEPTH = 1 << AW;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk, rst, kclk, kd, rdy_i;
    logic [7:0] dat_o;
    logic       vld_o, err_par_o, err_frm_o, ovf_o, busy_o;

    int checks   = 0;
    int failures = 0;
    int n_par    = 0;
    int n_frm    = 0;
    int n_ovf    = 0;
    logic [7:0] exp_q[$];

    ps2_kbd_rx #(
        .CLK_FREQ   (1_000_000),
        .FILTER_LEN (8),
        .FIFO_AW    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kclk      (kclk),
        .kd        (kd),
        .dat_o     (dat_o),
        .vld_o     (vld_o),
        .rdy_i     (rdy_i),
        .err_par_o (err_par_o),
        .err_frm_o (err_frm_o),
        .ovf_o     (ovf_o),
        .busy_o    (busy_o)
    );

    // Clock and pulse monitor.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err_par_o) n_par++;
        if (err_frm_o) n_frm++;
        if (ovf_o)     n_ovf++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        kd = b;
        wait_clk(10);
        if (glitch) begin
            kclk = 1'b0;
            wait_clk(3);
            kclk = 1'b1;
            wait_clk(10);
        end
        kclk = 1'b0;
        wait_clk(20);
        kclk = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic stop,
                              input int nbits, input bit glitch);
        logic [10:0] f;
        f = {stop, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], glitch && (i == 3));
        kd = 1'b1;
    endtask

    task automatic pop_one();
        rdy_i = 1'b1;
        @(posedge clk);
        #1 rdy_i = 1'b0;
    endtask

    // Scenarios.
    task automatic test_reset();
        rst = 1'b1; kclk = 1'b1; kd = 1'b1; rdy_i = 1'b0;
        wait_clk(3);
        @(negedge clk);
        checks++;
        if ({dat_o, vld_o, busy_o, err_par_o, err_frm_o, ovf_o} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state: dat=%h vld=%b busy=%b par=%b frm=%b ovf=%b, want all 0",
                     dat_o, vld_o, busy_o, err_par_o, err_frm_o, ovf_o);
        end
        rst = 1'b0;
        wait_clk(20);
    endtask

    task automatic test_good_frame();
        int p0, f0;
        p0 = n_par; f0 = n_frm;
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        checks++;
        if (vld_o !== 1'b1 || dat_o !== 8'h1C) begin
            failures++;
            $display("FAIL good_1c: vld=%b dat=%h, want vld=1 dat=1c", vld_o, dat_o);
        end
        checks++;
        if (n_par != p0 || n_frm != f0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL good_1c_flags: par=%0d frm=%0d busy=%b, want 0 0 0",
                     n_par - p0, n_frm - f0, busy_o);
        end
        pop_one();
        @(negedge clk);
        checks++;
        if (vld_o !== 1'b0) begin
            failures++;
            $display("FAIL pop_1c: vld=%b, want 0", vld_o);
        end
    endtask

    task automatic test_parity_err();
        int p0, f0;
        p0 = n_par; f0 = n_frm;
        send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
        @(negedge clk);
        checks++;
        if (n_par - p0 != 1 || n_frm != f0 || vld_o !== 1'b0) begin
            failures++;
            $display("FAIL parity_f0: par=%0d frm=%0d vld=%b, want 1 0 0",
                     n_par - p0, n_frm - f0, vld_o);
        end
    endtask

    task automatic test_stop_err();
        int p0, f0;
        p0 = n_par; f0 = n_frm;
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b0);
        @(negedge clk);
        checks++;
        if (n_frm - f0 != 1 || n_par != p0 || vld_o !== 1'b0) begin
            failures++;
            $display("FAIL stop_5a: frm=%0d par=%0d vld=%b, want 1 0 0",
                     n_frm - f0, n_par - p0, vld_o);
        end
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        checks++;
        if (vld_o !== 1'b1 || dat_o !== 8'h29) begin
            failures++;
            $display("FAIL after_stop_29: vld=%b dat=%h, want 1 29", vld_o, dat_o);
        end
        pop_one();
    endtask

    task automatic test_timeout();
        int f0;
        f0 = n_frm;
        send_frame(8'h34, 1'b0, 1'b1, 9, 1'b0);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || n_frm != f0) begin
            failures++;
            $display("FAIL timeout_pre: busy=%b frm=%0d, want 1 0", busy_o, n_frm - f0);
        end
        wait_clk(150);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || n_frm - f0 != 1 || vld_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_post: busy=%b frm=%0d vld=%b, want 0 1 0",
                     busy_o, n_frm - f0, vld_o);
        end
        send_frame(8'h12, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        checks++;
        if (vld_o !== 1'b1 || dat_o !== 8'h12) begin
            failures++;
            $display("FAIL after_timeout_12: vld=%b dat=%h, want 1 12", vld_o, dat_o);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        int o0, o_before_last;
        rdy_i = 1'b0;
        o0 = n_ovf;
        o_before_last = 0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            if (i == DEPTH + 1) o_before_last = n_ovf - o0;
            send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0);
            if (i <= DEPTH) exp_q.push_back(8'(i));
        end
        @(negedge clk);
        checks++;
        if (o_before_last != 0 || n_ovf - o0 != 1) begin
            failures++;
            $display("FAIL overflow: ovf before last=%0d total=%0d, want 0 1",
                     o_before_last, n_ovf - o0);
        end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            @(negedge clk);
            checks++;
            if (vld_o !== 1'b1 || dat_o !== e) begin
                failures++;
                $display("FAIL drain: vld=%b dat=%h, want 1 %h", vld_o, dat_o, e);
            end
            pop_one();
        end
        @(negedge clk);
        checks++;
        if (vld_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: vld=%b, want 0", vld_o);
        end
    endtask

    task automatic test_glitch_and_reset();
        int p0, f0, o0;
        p0 = n_par; f0 = n_frm; o0 = n_ovf;
        kclk = 1'b0;
        wait_clk(3);
        kclk = 1'b1;
        wait_clk(20);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || vld_o !== 1'b0 || n_par != p0 || n_frm != f0) begin
            failures++;
            $display("FAIL glitch_idle: busy=%b vld=%b par=%0d frm=%0d, want 0 0 0 0",
                     busy_o, vld_o, n_par - p0, n_frm - f0);
        end
        send_frame(8'h33, 1'b0, 1'b1, 11, 1'b1);
        @(negedge clk);
        checks++;
        if (vld_o !== 1'b1 || dat_o !== 8'h33 || n_par != p0 || n_frm != f0) begin
            failures++;
            $display("FAIL glitch_data: vld=%b dat=%h par=%0d frm=%0d, want 1 33 0 0",
                     vld_o, dat_o, n_par - p0, n_frm - f0);
        end
        // Leave 0x33 queued, start a frame, then reset in the middle of it.
        send_frame(8'h55, 1'b0, 1'b1, 5, 1'b0);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL midframe_busy: busy=%b, want 1", busy_o);
        end
        rst = 1'b1;
        wait_clk(2);
        @(negedge clk);
        checks++;
        if (vld_o !== 1'b0 || busy_o !== 1'b0 || dat_o !== 8'h00) begin
            failures++;
            $display("FAIL midframe_reset: vld=%b busy=%b dat=%h, want 0 0 00",
                     vld_o, busy_o, dat_o);
        end
        rst = 1'b0;
        wait_clk(20);
        checks++;
        if (n_par != p0 || n_frm != f0 || n_ovf != o0) begin
            failures++;
            $display("FAIL reset_no_pulse: par=%0d frm=%0d ovf=%0d, want 0 0 0",
                     n_par - p0, n_frm - f0, n_ovf - o0);
        end
        send_frame(8'h66, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        checks++;
        if (vld_o !== 1'b1 || dat_o !== 8'h66) begin
            failures++;
            $display("FAIL after_reset_66: vld=%b dat=%h, want 1 66", vld_o, dat_o);
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_stop_err();
        test_timeout();
        test_overflow();
        test_glitch_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
